// File: rtl/fft_bfly_unloader_if.sv
// fft_bfly_unloader_if: frame-in / sample-out bundle for the butterfly unloader.
//
// Parameters
//   N          sample width in bits (two's complement, real and imaginary each)
//
// Signals
//   in_valid   frame on in0..in3 is valid                    (upstream -> unloader)
//   in_ready   unloader can accept a frame this cycle        (unloader -> upstream)
//   inK_r/_i   butterfly results, index K = 0..3             (upstream -> unloader)
//   out_valid  out_r/out_i hold a valid sample               (unloader -> downstream)
//   out_ready  downstream accepts the sample                 (downstream -> unloader)
//   out_r/_i   current sample                                (unloader -> downstream)
//   out_idx    index 0..3 of the current sample in its frame (unloader -> downstream)
//   out_last   high on the last sample of a frame            (unloader -> downstream)
//
// Modports
//   slave   the unloader's view
//   master  the environment's view (upstream producer plus downstream consumer)
interface fft_bfly_unloader_if #(
  parameter int unsigned N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in0_r;
  logic [N-1:0] in0_i;
  logic [N-1:0] in1_r;
  logic [N-1:0] in1_i;
  logic [N-1:0] in2_r;
  logic [N-1:0] in2_i;
  logic [N-1:0] in3_r;
  logic [N-1:0] in3_i;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_r;
  logic [N-1:0] out_i;
  logic [1:0]   out_idx;
  logic         out_last;

  modport slave (
    input  in_valid, in0_r, in0_i, in1_r, in1_i, in2_r, in2_i, in3_r, in3_i, out_ready,
    output in_ready, out_valid, out_r, out_i, out_idx, out_last
  );

  modport master (
    output in_valid, in0_r, in0_i, in1_r, in1_i, in2_r, in2_i, in3_r, in3_i, out_ready,
    input  in_ready, out_valid, out_r, out_i, out_idx, out_last
  );
endinterface

// File: rtl/fft_bfly_unloader.sv
// fft_bfly_unloader: parallel-to-serial unloader behind a radix-4 butterfly stage.
//
// Captures a frame of four complex samples in one cycle and streams them out one sample
// per cycle over valid/ready. Two frame slots form a ping-pong buffer so a new frame can
// be captured while the previous one drains.
//
// Parameters
//   N   sample width (two's complement, real and imaginary each)
//   Q   fractional bits; carried through unchanged, informational only
//
// Ports
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset; discards any partially drained frame
//   bus  fft_bfly_unloader_if.slave (frame input handshake, sample output handshake)
//
// Build option
//   FFT_OUT_SCALE_EN  when defined, each output component is (x + 1) >>> 1
//                     (divide by 2, round half up, never overflows). When undefined,
//                     outputs equal the stored words bit-exactly.
module fft_bfly_unloader #(
  parameter int unsigned N = 8,
  parameter int unsigned Q = 4
) (
  input logic                clk,
  input logic                rst,
  fft_bfly_unloader_if.slave bus
);

  if (Q >= N) begin : g_bad_q
    $error("fft_bfly_unloader: Q must be smaller than N");
  end

  // Two slots of four complex words each.
  logic [N-1:0] slot_r_q [2][4];
  logic [N-1:0] slot_i_q [2][4];

  logic       wr_sel_q, wr_sel_d;
  logic       rd_sel_q, rd_sel_d;
  logic [1:0] rd_cnt_q, rd_cnt_d;
  logic [1:0] used_q,   used_d;

  logic in_ready;
  logic out_valid;
  logic accept;
  logic xfer;
  logic frame_done;

  // Handshake flags come straight from registered state only.
  assign in_ready   = (used_q != 2'd2);
  assign out_valid  = (used_q != 2'd0);
  assign accept     = bus.in_valid && in_ready;
  assign xfer       = out_valid && bus.out_ready;
  assign frame_done = xfer && (rd_cnt_q == 2'd3);

  // Slot storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        for (int w = 0; w < 4; w++) begin
          slot_r_q[s][w] <= '0;
          slot_i_q[s][w] <= '0;
        end
      end
    end else if (accept) begin
      slot_r_q[wr_sel_q][0] <= bus.in0_r;
      slot_i_q[wr_sel_q][0] <= bus.in0_i;
      slot_r_q[wr_sel_q][1] <= bus.in1_r;
      slot_i_q[wr_sel_q][1] <= bus.in1_i;
      slot_r_q[wr_sel_q][2] <= bus.in2_r;
      slot_i_q[wr_sel_q][2] <= bus.in2_i;
      slot_r_q[wr_sel_q][3] <= bus.in3_r;
      slot_i_q[wr_sel_q][3] <= bus.in3_i;
    end
  end

  // Pointer and occupancy next state.
  always_comb begin
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    rd_cnt_d = rd_cnt_q;
    used_d   = used_q;

    if (accept) begin
      wr_sel_d = ~wr_sel_q;
    end
    if (xfer) begin
      rd_cnt_d = rd_cnt_q + 2'd1;  // wraps 3 -> 0 at frame end
    end
    if (frame_done) begin
      rd_sel_d = ~rd_sel_q;
    end

    // Accept and completion on the same edge cancel out.
    unique case ({accept, frame_done})
      2'b10:   used_d = used_q + 2'd1;
      2'b01:   used_d = used_q - 2'd1;
      default: used_d = used_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      rd_cnt_q <= 2'd0;
      used_q   <= 2'd0;
    end else begin
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      rd_cnt_q <= rd_cnt_d;
      used_q   <= used_d;
    end
  end

  // Output path: combinational from registers.
  logic [N-1:0] cur_r;
  logic [N-1:0] cur_i;

  assign cur_r = slot_r_q[rd_sel_q][rd_cnt_q];
  assign cur_i = slot_i_q[rd_sel_q][rd_cnt_q];

`ifdef FFT_OUT_SCALE_EN
  // (x + 1) >>> 1 equals floor(x / 2) plus the dropped lsb; this form needs no extra bit
  // and the sum cannot overflow because floor(x / 2) is at most 2^(N-2) - 1.
  assign bus.out_r = {cur_r[N-1], cur_r[N-1:1]} + {{(N-1){1'b0}}, cur_r[0]};
  assign bus.out_i = {cur_i[N-1], cur_i[N-1:1]} + {{(N-1){1'b0}}, cur_i[0]};
`else
  assign bus.out_r = cur_r;
  assign bus.out_i = cur_i;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_idx   = rd_cnt_q;
  assign bus.out_last  = out_valid && (rd_cnt_q == 2'd3);

endmodule

// File: tb/tb_fft_bfly_unloader.sv
// Self-checking bench for fft_bfly_unloader: table of single frames plus hand-written
// multi-cycle sequences (back-to-back frames, backpressure, same-edge accept/complete,
// asynchronous reset mid-drain). Inputs change and outputs are sampled on the falling edge.
module tb_fft_bfly_unloader;
  localparam int unsigned N = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  fft_bfly_unloader_if #(.N(N)) bus ();

  fft_bfly_unloader #(.N(N), .Q(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef logic [3:0][7:0] frame_t;

  typedef struct packed {
    frame_t in_r;
    frame_t in_i;
    frame_t exp_r;
    frame_t exp_i;
  } vec_t;

  vec_t vecs [2];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic frame_t mk(input int a, input int b, input int c, input int d);
    frame_t f;
    f[0] = a[7:0];
    f[1] = b[7:0];
    f[2] = c[7:0];
    f[3] = d[7:0];
    return f;
  endfunction

  // Expected output for a stored value: floor((x + 1) / 2) when scaling, else x.
  function automatic int ref_out(input int x);
`ifdef FFT_OUT_SCALE_EN
    int s;
    s = x + 1;
    if (s >= 0) return s / 2;
    return -((1 - s) / 2);
`else
    return x;
`endif
  endfunction

  function automatic int sx(input logic [7:0] v);
    return int'($signed(v));
  endfunction

  task automatic drive_frame(input frame_t r, input frame_t im);
    bus.in_valid = 1'b1;
    bus.in0_r = r[0]; bus.in0_i = im[0];
    bus.in1_r = r[1]; bus.in1_i = im[1];
    bus.in2_r = r[2]; bus.in2_i = im[2];
    bus.in3_r = r[3]; bus.in3_i = im[3];
  endtask

  task automatic expect_sample(input string tag, input int er, input int ei, input int idx);
    check({tag, " out_valid"}, int'(bus.out_valid), 1);
    check({tag, " out_r"}, sx(bus.out_r), er);
    check({tag, " out_i"}, sx(bus.out_i), ei);
    check({tag, " out_idx"}, int'(bus.out_idx), idx);
    check({tag, " out_last"}, int'(bus.out_last), (idx == 3) ? 1 : 0);
  endtask

  task automatic expect_reset_outputs(input string tag);
    check({tag, " in_ready"}, int'(bus.in_ready), 1);
    check({tag, " out_valid"}, int'(bus.out_valid), 0);
    check({tag, " out_r"}, sx(bus.out_r), 0);
    check({tag, " out_i"}, sx(bus.out_i), 0);
    check({tag, " out_idx"}, int'(bus.out_idx), 0);
    check({tag, " out_last"}, int'(bus.out_last), 0);
  endtask

  // Streams a frame already driven on the bus with out_ready high, checking all samples.
  task automatic drain_frame(input string tag, input frame_t r, input frame_t im);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) bus.in_valid = 1'b0;
      expect_sample($sformatf("%s s%0d", tag, k), ref_out(sx(r[k])), ref_out(sx(im[k])), k);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    frame_t fa_r, fa_i, fb_r, fb_i, fc_r, fc_i;
    int     er [12];
    int     ei [12];
    int     ready_exp [12];

    vecs[0].in_r = mk(1, 2, 3, 4);
    vecs[0].in_i = mk(-1, -2, -3, -4);
    vecs[1].in_r = mk(127, 3, 0, -128);
    vecs[1].in_i = mk(-128, -3, -1, 127);
`ifdef FFT_OUT_SCALE_EN
    vecs[0].exp_r = mk(1, 1, 2, 2);
    vecs[0].exp_i = mk(0, -1, -1, -2);
    vecs[1].exp_r = mk(64, 2, 0, -64);
    vecs[1].exp_i = mk(-64, -1, 0, 64);
`else
    vecs[0].exp_r = mk(1, 2, 3, 4);
    vecs[0].exp_i = mk(-1, -2, -3, -4);
    vecs[1].exp_r = mk(127, 3, 0, -128);
    vecs[1].exp_i = mk(-128, -3, -1, 127);
`endif

    rst = 1'b1;
    bus.out_ready = 1'b0;
    drive_frame(mk(0, 0, 0, 0), mk(0, 0, 0, 0));
    bus.in_valid = 1'b0;
    #12;
    expect_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Single frames from the table.
    for (int v = 0; v < 2; v++) begin
      @(negedge clk);
      check($sformatf("vec%0d in_ready before", v), int'(bus.in_ready), 1);
      drive_frame(vecs[v].in_r, vecs[v].in_i);
      bus.out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (k == 0) bus.in_valid = 1'b0;
        expect_sample($sformatf("vec%0d s%0d", v, k), sx(vecs[v].exp_r[k]),
                      sx(vecs[v].exp_i[k]), k);
        check($sformatf("vec%0d s%0d in_ready", v, k), int'(bus.in_ready), 1);
      end
      @(negedge clk);
      check($sformatf("vec%0d idle out_valid", v), int'(bus.out_valid), 0);
      check($sformatf("vec%0d idle in_ready", v), int'(bus.in_ready), 1);
    end

    // Two back-to-back frames while stalled, third held off, then continuous drain.
    fa_r = mk(10, 11, 12, 13); fa_i = mk(-10, -11, -12, -13);
    fb_r = mk(20, 21, 22, 23); fb_i = mk(-20, -21, -22, -23);
    fc_r = mk(30, 31, 32, 33); fc_i = mk(-30, -31, -32, -33);
    for (int k = 0; k < 4; k++) begin
      er[k]     = ref_out(sx(fa_r[k])); ei[k]     = ref_out(sx(fa_i[k]));
      er[k + 4] = ref_out(sx(fb_r[k])); ei[k + 4] = ref_out(sx(fb_i[k]));
      er[k + 8] = ref_out(sx(fc_r[k])); ei[k + 8] = ref_out(sx(fc_i[k]));
    end
    ready_exp = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 1};
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive_frame(fa_r, fa_i);
    @(negedge clk);
    check("b2b second ready", int'(bus.in_ready), 1);
    drive_frame(fb_r, fb_i);
    @(negedge clk);
    check("b2b full in_ready", int'(bus.in_ready), 0);
    check("b2b full out_valid", int'(bus.out_valid), 1);
    drive_frame(fc_r, fc_i);
    @(negedge clk);
    check("b2b held in_ready", int'(bus.in_ready), 0);
    bus.out_ready = 1'b1;
    for (int j = 0; j < 12; j++) begin
      if (j > 0) @(negedge clk);
      if (j == 5) bus.in_valid = 1'b0;
      expect_sample($sformatf("b2b j%0d", j), er[j], ei[j], j % 4);
      check($sformatf("b2b j%0d in_ready", j), int'(bus.in_ready), ready_exp[j]);
    end
    @(negedge clk);
    check("b2b end out_valid", int'(bus.out_valid), 0);

    // Backpressure while sample 2 is presented.
    fa_r = mk(40, -41, 42, -43); fa_i = mk(44, -45, 46, -47);
    drive_frame(fa_r, fa_i);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) bus.in_valid = 1'b0;
      expect_sample($sformatf("bp s%0d", k), ref_out(sx(fa_r[k])), ref_out(sx(fa_i[k])), k);
    end
    bus.out_ready = 1'b0;
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      expect_sample($sformatf("bp hold%0d", h), ref_out(sx(fa_r[2])), ref_out(sx(fa_i[2])), 2);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    expect_sample("bp s3", ref_out(sx(fa_r[3])), ref_out(sx(fa_i[3])), 3);
    @(negedge clk);
    check("bp end out_valid", int'(bus.out_valid), 0);

    // New frame accepted on the same edge the previous frame completes.
    fa_r = mk(50, 51, 52, 53); fa_i = mk(-50, -51, -52, -53);
    fb_r = mk(60, 61, 62, 63); fb_i = mk(-60, -61, -62, -63);
    drive_frame(fa_r, fa_i);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) bus.in_valid = 1'b0;
      expect_sample($sformatf("sim e%0d", k), ref_out(sx(fa_r[k])), ref_out(sx(fa_i[k])), k);
    end
    check("sim in_ready at e3", int'(bus.in_ready), 1);
    drive_frame(fb_r, fb_i);
    drain_frame("sim f", fb_r, fb_i);
    check("sim used stays one", int'(bus.in_ready), 1);
    @(negedge clk);
    check("sim end out_valid", int'(bus.out_valid), 0);
    check("sim end in_ready", int'(bus.in_ready), 1);

    // Asynchronous reset in the middle of a drain.
    fa_r = mk(70, 71, 72, 73); fa_i = mk(-70, -71, -72, -73);
    drive_frame(fa_r, fa_i);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (k == 0) bus.in_valid = 1'b0;
      expect_sample($sformatf("rst g%0d", k), ref_out(sx(fa_r[k])), ref_out(sx(fa_i[k])), k);
    end
    bus.out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    expect_reset_outputs("rst async");
    @(negedge clk);
    rst = 1'b0;
    expect_reset_outputs("rst released");
    fb_r = mk(80, -81, 82, -83); fb_i = mk(-84, 85, -86, 87);
    drive_frame(fb_r, fb_i);
    bus.out_ready = 1'b1;
    drain_frame("rst h", fb_r, fb_i);
    @(negedge clk);
    check("rst end out_valid", int'(bus.out_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_bfly_unloader.md
# fft_bfly_unloader

Parallel-to-serial unloader on the output side of a radix-4 butterfly stage in the 32-point DIT FFT. It captures one frame of four complex results (out0..out3) in a single cycle and streams them one sample per cycle over a valid/ready interface to the next stage or to the output port. Two frame slots form a ping-pong buffer, so the butterfly can deliver a new frame while the previous one drains.

## Interface
- N, 8, sample width in bits (two's complement, real and imaginary each)
- Q, 4, fractional bits; carried through unchanged, used only for documentation and scaling consistency
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  frame on in0..in3 is valid
- in_ready  out  1  unloader can accept a frame this cycle
- in0_r, in0_i, in1_r, in1_i, in2_r, in2_i, in3_r, in3_i  in  N each  butterfly results, index 0..3
- out_valid  out  1  out_r/out_i hold a valid sample
- out_ready  in  1  downstream accepts the sample
- out_r, out_i  out  N each  current sample
- out_idx  out  2  index (0..3) of the current sample within its frame
- out_last  out  1  high when out_idx == 3 and out_valid

## Operation
- Storage: slot[0..1], each holding 4 complex words. Registers: wr_sel (1 bit), rd_sel (1 bit), rd_cnt (2 bits), used (0..2).
- Per-slot state: EMPTY -> FULL on a frame accept into that slot. FULL -> EMPTY when the sample at rd_cnt == 3 of that slot is accepted.
- in_ready = (used < 2). It depends only on registered state, never on out_ready.
- Accept: in_valid && in_ready at a rising edge. All eight inputs are written into slot[wr_sel], and wr_sel toggles. in_valid while in_ready is low is ignored; no data is lost, and the upstream holds the frame.
- out_valid = (used > 0). out_r/out_i = slot[rd_sel][rd_cnt], after optional scaling. out_idx = rd_cnt.
- Transfer: out_valid && out_ready at a rising edge. rd_cnt increments. At rd_cnt == 3 it wraps to 0, rd_sel toggles, and the slot frees.
- While out_valid && !out_ready, out_r, out_i, out_idx and out_last hold stable.
- used update: +1 on accept only, -1 on a frame-completing transfer only. Unchanged when both occur in the same edge.
- Full: used == 2 with a frame completing this cycle still shows in_ready low. The new frame is accepted on the next edge (one-cycle bubble, by design).
- Empty: out_valid low. out_r, out_i and out_idx still show slot[rd_sel][rd_cnt]; the value is don't-care for consumers.
- Reset (any time, including mid-frame): used=0, wr_sel=0, rd_sel=0, rd_cnt=0, all slot words 0. The partially drained frame is discarded.
- Output reset values: in_ready=1, out_valid=0, out_r=0, out_i=0, out_idx=0, out_last=0.

## Timing
- Frame accepted at edge k: out_valid=1, sample 0 visible in cycle k+1 (1-cycle latency). The output path is combinational from registers.
- Drain: 4 transfers. With out_ready held high, samples 0..3 occupy cycles k+1..k+4.
- Sustained throughput: 1 frame per 4 cycles, 1 sample per cycle, with no output bubbles between back-to-back frames.
- No combinational path from in_valid or out_ready to in_ready or out_valid.

## Configuration
- FFT_OUT_SCALE_EN defined: each output component is (x + 1) >>> 1, computed in N+1 bits then truncated to N bits. This divides by 2 with round-half-up and never overflows. Used to cap bit growth per stage.
- FFT_OUT_SCALE_EN undefined: out_r/out_i equal the stored words bit-exactly.
- Storage, handshake and timing are identical in both builds.

## Test plan
- Reset, then a single frame in0..in3 = (1,-1),(2,-2),(3,-3),(4,-4) with out_ready=1: out_valid in cycles k+1..k+4, samples in order, out_idx 0..3, out_last only on the 4th sample. Then out_valid=0 and in_ready=1 throughout.
- Two frames on consecutive cycles with out_ready=0: both accepted and in_ready drops to 0. A third in_valid is held off. Release out_ready: 8 samples out in order with no gaps, and the third frame is accepted one cycle after the first frame's last transfer.
- Backpressure mid-frame: drop out_ready while out_idx=2 for 3 cycles. out_r, out_i and out_idx stay stable, and sample 3 follows once out_ready returns.
- Simultaneous accept and frame completion with used=1: used stays 1, the new frame's sample 0 follows the old sample 3 on the next cycle, and wr_sel and rd_sel both toggle.
- Assert rst mid-drain (after out_idx=1): outputs go to their reset values immediately (asynchronously). After release, the next frame starts at out_idx=0 from slot 0.
- With FFT_OUT_SCALE_EN and N=8, inputs 127, -128, 3, -3: outputs 64, -64, 2, -1. Without the macro, the outputs equal the inputs.
